sad_buffer_unit: RTL and testbench
==================================

# sad_buffer_unit

Holds the two pixel operand buffers for the SAD extension: buffer A (window) and buffer B (frame). It is the responder to the buffer commands decoded in ID: `lbufa`, `lbufb`, `sad_a` (window shift), `sad_b` (frame shift) and `buf` (clear). It fills or shifts the buffers with memory read data, computes a pipelined sum of absolute byte differences, and returns `all_buf_flags` to the control unit. The control unit holds an `abuf` instruction in ID until that flag is high.

## Interface
- `DEPTH`, default 4: number of 32-bit words per buffer; must be ≥2.
- `DATA_W`, default 32: word width; must be a multiple of 8.
- `Clk`  in  1  system clock; all state updates on the rising edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `MEM_load_buff_a`  in  1  write `MEM_ReadData` into A at A's write pointer.
- `MEM_load_buff_b`  in  1  same operation for B.
- `MEM_window_shift`  in  1  shift A by one word; `MEM_ReadData` enters the top slot.
- `MEM_frame_shift`  in  1  same operation for B.
- `MEM_buff`  in  1  clear both buffers.
- `MEM_ReadData`  in  `DATA_W`  word from data memory, same cycle as the command.
- `sad_result`  out  32  registered SAD of A vs B, zero-extended.
- `sad_valid`  out  1  `sad_result` reflects the current buffer contents.
- `all_buf_flags`  out  1  both buffers are fully valid and `sad_valid` is high.

## Operation
- Each buffer holds `DEPTH` words, one valid bit per word, and a write pointer `wp` of width clog2(`DEPTH`).
- **Load:**
  - Write slot `wp` and set its valid bit.
  - `wp` increments and wraps from `DEPTH-1` to 0. On wrap, the next load overwrites slot 0 with no error.
- **Shift:**
  - slot[i] takes slot[i+1] for i < `DEPTH-1`.
  - slot[`DEPTH-1`] takes `MEM_ReadData` and is marked valid.
  - Valid bits shift in the same way. `wp` is unchanged.
- **Clear:** all valid bits and both `wp` go to 0. Data words are not cleared.
- **Priority per buffer in one cycle:** clear > shift > load. The losing commands are ignored.
- Commands to A and to B in the same cycle are independent, and both take effect.
- **SAD definition:**
  - Sum over all `DEPTH`·`DATA_W`/8 byte pairs of |A_byte − B_byte|, with bytes treated as unsigned.
  - Byte k of word w in A pairs with byte k of word w in B.
  - Result width is 8 + clog2(`DEPTH`·`DATA_W`/8), which is 12 bits at the defaults, zero-extended to 32.
- **SAD pipeline:**
  - S1 registers the per-byte absolute differences.
  - S2 registers the adder-tree sum into `sad_result`.
- **Dirty tracking:**
  - Any buffer update sets a 2-bit settle counter to 2. The counter decrements to 0 on each cycle with no update.
  - `sad_valid` = (counter == 0) & all valid bits set in A & all valid bits set in B.
- `all_buf_flags` = `sad_valid`. It is registered-derived and has no combinational path from the command inputs.

## Timing
- **Reset values:**
  - `sad_result`=0, `sad_valid`=0, `all_buf_flags`=0.
  - All valid bits 0, `wp`=0, settle counter 0.
  - Data and S1 registers are 0.
- Reset asserted mid-operation aborts the pipeline. Outputs return to their reset values asynchronously.
- **Update latency:** a command in cycle t modifies the buffer at edge t+1.
  - S1 captures the new differences at edge t+2.
  - `sad_result` is updated at edge t+3.
  - `sad_valid` rises after edge t+3 if both buffers are full and no further update occurs in t+1..t+2.
- Back-to-back updates keep `sad_valid` low until 2 full cycles pass with no update.
- Clear in cycle t drops `sad_valid` and `all_buf_flags` after edge t+1.
- **Stall interaction:** ID stalls on `abuf` while `all_buf_flags`=0. The unit has no handshake back to MEM; commands are never back-pressured.

## Structure
- The shared package `sad_pkg` holds:
  - `SAD_W` function of `DEPTH` and `DATA_W`;
  - the command opcode constants (`SAD_A`=6'b011101, `SAD_B`=6'b010110, `LBUFA`=6'b010011, `LBUFB`=6'b110011) and funct constants (`BUF`=6'b010101, `ABUF`=6'b010111), shared with the control unit.
- One sub-module, `sad_line_buffer`, instantiated twice: data words, valid bits, `wp`, and load/shift/clear logic. It exposes a flat data bus, a `full` output and an `updated` pulse.
- The top level contains the SAD pipeline, the settle counter and the flag logic.

## Test plan
- **Reset defaults:** assert `Reset` mid-fill → all outputs 0 immediately; after release, `all_buf_flags`=0.
- **Fill and compute:**
  - Stimulus: 4 `lbufa` loads of 0x01010101, then 4 `lbufb` loads of 0x03030303.
  - Required response: 3 cycles after the last load, `sad_result`=32 and `all_buf_flags`=1.
- **Shift:**
  - Stimulus: from the filled state, `sad_a` with `MEM_ReadData`=0x03030303.
  - Required response: `sad_valid` is low for 3 cycles, then `sad_result`=24.
- **Absolute value and max:**
  - Stimulus: A all 0x00000000, B all 0xFFFFFFFF.
  - Required response: `sad_result`=4080. Swapping A and B gives the same result.
- **Priority:**
  - `lbufa` and `sad_a` in the same cycle → only the shift applies and `wp` is unchanged.
  - `buf` together with any command → both buffers are empty and `all_buf_flags`=0 next cycle.
- **Wrap:** a 5th `lbufa` with 0xAA000000 overwrites slot 0, and the flag returns after the 3-cycle settle.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared definitions for the SAD extension: result width helper and the
// opcode/funct encodings shared with the control unit.
package sad_pkg;

  localparam logic [5:0] SAD_A = 6'b011101;
  localparam logic [5:0] SAD_B = 6'b010110;
  localparam logic [5:0] LBUFA = 6'b010011;
  localparam logic [5:0] LBUFB = 6'b110011;

  localparam logic [5:0] BUF   = 6'b010101;
  localparam logic [5:0] ABUF  = 6'b010111;

  // Worst case sum is 255 * byte_count, so 8 bits plus the count's log2.
  function automatic int unsigned SAD_W(input int unsigned depth, input int unsigned data_w);
    return 8 + $clog2(depth * data_w / 8);
  endfunction

endpackage

// File: rtl/sad_line_buffer.sv
// One SAD operand buffer: DEPTH words with per-word valid bits and a write
// pointer; supports load at the pointer, shift-in at the top, and clear.
module sad_line_buffer #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      load_i,
  input  logic                      shift_i,
  input  logic                      clear_i,
  input  logic [DATA_W-1:0]         wr_data_i,
  output logic [DEPTH*DATA_W-1:0]   data_o,
  output logic                      full_o,
  output logic                      updated_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [PtrW-1:0]              wp_q, wp_d;

  // Clear wins over shift, shift wins over load; data words survive a clear.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    wp_d    = wp_q;
    if (clear_i) begin
      valid_d = '0;
      wp_d    = '0;
    end else if (shift_i) begin
      for (int i = 0; i < int'(DEPTH) - 1; i++) begin
        data_d[i]  = data_q[i+1];
        valid_d[i] = valid_q[i+1];
      end
      data_d[DEPTH-1]  = wr_data_i;
      valid_d[DEPTH-1] = 1'b1;
    end else if (load_i) begin
      data_d[wp_q]  = wr_data_i;
      valid_d[wp_q] = 1'b1;
      wp_d          = (wp_q == PtrW'(DEPTH - 1)) ? '0 : wp_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      valid_q <= '0;
      wp_q    <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      wp_q    <= wp_d;
    end
  end

  assign data_o    = data_q;
  assign full_o    = &valid_q;
  assign updated_o = load_i | shift_i | clear_i;

endmodule

// File: rtl/sad_buffer_unit.sv
// SAD operand buffers A/B with a two-stage sum-of-absolute-differences pipeline
// and the settle tracking behind all_buf_flags.
module sad_buffer_unit
  import sad_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MEM_load_buff_a,
  input  logic              MEM_load_buff_b,
  input  logic              MEM_window_shift,
  input  logic              MEM_frame_shift,
  input  logic              MEM_buff,
  input  logic [DATA_W-1:0] MEM_ReadData,
  output logic [31:0]       sad_result,
  output logic              sad_valid,
  output logic              all_buf_flags
);

  localparam int unsigned NBytes = DEPTH * DATA_W / 8;
  localparam int unsigned SadW   = SAD_W(DEPTH, DATA_W);

  logic [DEPTH*DATA_W-1:0] data_a, data_b;
  logic                    full_a, full_b;
  logic                    upd_a, upd_b;

  sad_line_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_buf_a (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .load_i    (MEM_load_buff_a),
    .shift_i   (MEM_window_shift),
    .clear_i   (MEM_buff),
    .wr_data_i (MEM_ReadData),
    .data_o    (data_a),
    .full_o    (full_a),
    .updated_o (upd_a)
  );

  sad_line_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_buf_b (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .load_i    (MEM_load_buff_b),
    .shift_i   (MEM_frame_shift),
    .clear_i   (MEM_buff),
    .wr_data_i (MEM_ReadData),
    .data_o    (data_b),
    .full_o    (full_b),
    .updated_o (upd_b)
  );

  logic [NBytes-1:0][7:0] diff_d, diff_q;
  logic [SadW-1:0]        sum_d, sad_q;
  logic [1:0]             settle_d, settle_q;

  // Flat buses pair byte k of word w in A with the same position in B.
  always_comb begin
    for (int i = 0; i < int'(NBytes); i++) begin
      diff_d[i] = (data_a[i*8 +: 8] > data_b[i*8 +: 8]) ?
                  data_a[i*8 +: 8] - data_b[i*8 +: 8] :
                  data_b[i*8 +: 8] - data_a[i*8 +: 8];
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < int'(NBytes); i++) begin
      sum_d = sum_d + SadW'(diff_q[i]);
    end
  end

  // Two quiet cycles let a change ripple through S1 and S2.
  always_comb begin
    if (upd_a || upd_b)        settle_d = 2'd2;
    else if (settle_q != 2'd0) settle_d = settle_q - 2'd1;
    else                       settle_d = 2'd0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      diff_q   <= '0;
      sad_q    <= '0;
      settle_q <= '0;
    end else begin
      diff_q   <= diff_d;
      sad_q    <= sum_d;
      settle_q <= settle_d;
    end
  end

  assign sad_result    = 32'(sad_q);
  assign sad_valid     = (settle_q == 2'd0) && full_a && full_b;
  assign all_buf_flags = sad_valid;

endmodule

// File: tb/tb_sad_buffer_unit.sv
// Self-checking bench for sad_buffer_unit: directed scenarios with literal
// expectations plus randomized traffic against a behavioural buffer model.
module tb_sad_buffer_unit;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              la = 1'b0, lb = 1'b0, sa = 1'b0, sb = 1'b0, clr = 1'b0;
  logic [DATA_W-1:0] rd = '0;
  logic [31:0]       sad_result;
  logic              sad_valid, all_buf_flags;

  sad_buffer_unit #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .MEM_load_buff_a  (la),
    .MEM_load_buff_b  (lb),
    .MEM_window_shift (sa),
    .MEM_frame_shift  (sb),
    .MEM_buff         (clr),
    .MEM_ReadData     (rd),
    .sad_result       (sad_result),
    .sad_valid        (sad_valid),
    .all_buf_flags    (all_buf_flags)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: buffer contents, and the SAD seen one and two edges ago.
  logic [DEPTH-1:0][DATA_W-1:0] ma, mb;
  logic [DEPTH-1:0]             va, vb;
  int                           wpa, wpb;
  int                           s1_m, res_m, quiet;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic int sad_of(input logic [DEPTH*DATA_W-1:0] a,
                                input logic [DEPTH*DATA_W-1:0] b);
    int s = 0;
    for (int i = 0; i < DEPTH * DATA_W / 8; i++) begin
      int d = int'(a[i*8 +: 8]) - int'(b[i*8 +: 8]);
      s += (d < 0) ? -d : d;
    end
    return s;
  endfunction

  task automatic apply_buf(input logic ld, input logic sh, input logic cl,
                           input logic [DATA_W-1:0] d,
                           inout logic [DEPTH-1:0][DATA_W-1:0] w,
                           inout logic [DEPTH-1:0] v, inout int wp);
    if (cl) begin
      v  = '0;
      wp = 0;
    end else if (sh) begin
      w = {d, w[DEPTH-1:1]};
      v = {1'b1, v[DEPTH-1:1]};
    end else if (ld) begin
      w[wp] = d;
      v[wp] = 1'b1;
      wp    = (wp + 1) % DEPTH;
    end
  endtask

  task automatic model_reset();
    ma = '0; mb = '0; va = '0; vb = '0;
    wpa = 0; wpb = 0; s1_m = 0; res_m = 0; quiet = 2;
  endtask

  task automatic model_step();
    res_m = s1_m;
    s1_m  = sad_of(ma, mb);
    apply_buf(la, sa, clr, rd, ma, va, wpa);
    apply_buf(lb, sb, clr, rd, mb, vb, wpb);
    if (la || lb || sa || sb || clr) quiet = 0;
    else if (quiet < 2)              quiet++;
  endtask

  always @(negedge Clk) begin
    logic exp_v;
    exp_v = (quiet >= 2) && (&va) && (&vb);
    check("model sad_result", sad_result, 32'(res_m));
    check("model sad_valid", {31'd0, sad_valid}, {31'd0, exp_v});
    check("model all_buf_flags", {31'd0, all_buf_flags}, {31'd0, exp_v});
  end

  task automatic do_cycle(input logic l_a, input logic l_b, input logic s_a, input logic s_b,
                          input logic c, input logic [DATA_W-1:0] d);
    la = l_a; lb = l_b; sa = s_a; sb = s_b; clr = c; rd = d;
    @(posedge Clk);
    if (Reset) model_reset();
    else       model_step();
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(0, 0, 0, 0, 0, '0);
  endtask

  task automatic fill(input logic [DATA_W-1:0] da, input logic [DATA_W-1:0] db);
    for (int i = 0; i < DEPTH; i++) do_cycle(1, 0, 0, 0, 0, da);
    for (int i = 0; i < DEPTH; i++) do_cycle(0, 1, 0, 0, 0, db);
  endtask

  initial begin
    model_reset();
    idle(2);
    check("reset sad_result", sad_result, 32'd0);
    check("reset all_buf_flags", {31'd0, all_buf_flags}, 32'd0);
    Reset = 1'b0;
    idle(1);

    // Fill and compute: 16 bytes each differing by 2.
    fill(32'h01010101, 32'h03030303);
    idle(2);
    check("fill sad_result", sad_result, 32'd32);
    check("fill all_buf_flags", {31'd0, all_buf_flags}, 32'd1);

    // Window shift: top word of A now matches B.
    do_cycle(0, 0, 1, 0, 0, 32'h03030303);
    check("shift valid t+1", {31'd0, sad_valid}, 32'd0);
    idle(1);
    check("shift valid t+2", {31'd0, sad_valid}, 32'd0);
    idle(1);
    check("shift valid t+3", {31'd0, sad_valid}, 32'd1);
    check("shift sad_result", sad_result, 32'd24);

    // Clear together with a load: both buffers empty, flag drops.
    do_cycle(1, 1, 0, 0, 1, 32'h12345678);
    check("clear flags", {31'd0, all_buf_flags}, 32'd0);
    fill(32'h00000000, 32'hFFFFFFFF);
    idle(2);
    check("max sad_result", sad_result, 32'd4080);
    do_cycle(0, 0, 0, 0, 1, '0);
    fill(32'hFFFFFFFF, 32'h00000000);
    idle(2);
    check("swap sad_result", sad_result, 32'd4080);

    // Load+shift: only the shift applies, so the pointer stays at slot 0.
    do_cycle(1, 0, 1, 0, 0, 32'h00000000);
    do_cycle(1, 0, 0, 0, 0, 32'h00000000);
    do_cycle(0, 0, 1, 0, 0, 32'hFFFFFFFF);
    idle(2);
    check("priority sad_result", sad_result, 32'd3060);

    // Wrap: fifth load lands in slot 0.
    do_cycle(0, 0, 0, 0, 1, '0);
    fill(32'h01010101, 32'h03030303);
    idle(2);
    do_cycle(1, 0, 0, 0, 0, 32'hAA000000);
    check("wrap flag low", {31'd0, all_buf_flags}, 32'd0);
    idle(2);
    check("wrap flag back", {31'd0, all_buf_flags}, 32'd1);
    check("wrap sad_result", sad_result, 32'd200);

    // Asynchronous reset mid-operation, between clock edges.
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check("async rst sad_result", sad_result, 32'd0);
    check("async rst sad_valid", {31'd0, sad_valid}, 32'd0);
    check("async rst flags", {31'd0, all_buf_flags}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    idle(1);
    check("post rst flags", {31'd0, all_buf_flags}, 32'd0);

    // Reset part way through a fill, then finish filling from scratch.
    do_cycle(1, 0, 0, 0, 0, 32'h55555555);
    do_cycle(1, 0, 0, 0, 0, 32'h55555555);
    #2;
    Reset = 1'b1;
    model_reset();
    #1;
    check("midfill rst flags", {31'd0, all_buf_flags}, 32'd0);
    @(negedge Clk);
    Reset = 1'b0;
    idle(1);

    // Randomized traffic, with quiet stretches so the flag can rise.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 99) < 45) begin
        idle(1);
      end else begin
        do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 99) < 3), $urandom);
      end
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
